// File: rtl/inst_prefetch_queue_if.sv
// Bus bundle for the instruction prefetch queue: memory read port, redirect input,
// decoder-facing head entry, and the FSM state for observation.
interface inst_prefetch_queue_if #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 19,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Handshakes: imem_req/imem_addr hold until the cycle imem_ack=1 (single outstanding);
  // a head entry transfers on any cycle where inst_valid & deq_ready are both 1.
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              deq_ready;
  logic [CNT_W-1:0]  count;
  logic [1:0]        fsm_state;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, count, fsm_state,
    input  imem_ack, imem_rdata, flush, flush_pc, deq_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, count, fsm_state,
    output imem_ack, imem_rdata, flush, flush_pc, deq_ready
  );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words from instruction memory into a
// small FIFO for the decoder; flush redirects fetch and drops buffered/in-flight words.
module inst_prefetch_queue #(
  parameter int                  DATA_W   = 19,
  parameter int                  ADDR_W   = 19,
  parameter int                  DEPTH    = 4,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input logic clk,
  input logic reset,
  inst_prefetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d, count_after;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic              push, pop, has_room;

  always_comb begin
    push        = (state_q == REQ) && bus.imem_ack && !bus.flush;
    pop         = (count_q != '0) && bus.deq_ready && !bus.flush;
    count_after = count_q + CNT_W'(push) - CNT_W'(pop);
    has_room    = count_after < CNT_W'(DEPTH);

    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    count_d      = count_after;

    if (bus.flush) begin
      // Flush wins over push/pop; an unacked request must still complete before refetch.
      count_d    = '0;
      fetch_pc_d = bus.flush_pc;
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (bus.imem_ack) begin
            state_d = REQ;
          end else begin
            state_d      = DRAIN;
            drain_addr_d = fetch_pc_q;
          end
        end
        DRAIN:   state_d = bus.imem_ack ? REQ : DRAIN;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: if (has_room) state_d = REQ;
        REQ: begin
          if (bus.imem_ack) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            state_d    = has_room ? REQ : IDLE;
          end
        end
        DRAIN:   if (bus.imem_ack) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      count_q      <= count_d;
      if (bus.flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      data_mem[wr_ptr_q] <= bus.imem_rdata;
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  assign bus.imem_req   = (state_q != IDLE);
  assign bus.imem_addr  = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;
  assign bus.inst_valid = (count_q != '0);
  assign bus.inst       = bus.inst_valid ? data_mem[rd_ptr_q] : '0;
  assign bus.inst_pc    = bus.inst_valid ? pc_mem[rd_ptr_q] : '0;
  assign bus.count      = count_q;
  assign bus.fsm_state  = state_q;
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Randomized bench for inst_prefetch_queue: a bench-side memory with random wait states,
// a queue-level reference model feeding a scoreboard, and a decoupled pop monitor.
module tb_inst_prefetch_queue;
  localparam int DATA_W = 19;
  localparam int ADDR_W = 19;
  localparam int DEPTH  = 4;
  localparam int W      = DATA_W + ADDR_W;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;
  localparam int NPH    = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  inst_prefetch_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  inst_prefetch_queue #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int mem_wait_max = 0;

  logic [W-1:0] exp_q[$];

  function automatic logic [DATA_W-1:0] rdata_of(input logic [ADDR_W-1:0] addr);
    return DATA_W'(addr * 3 + 19'h100);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- memory driver ----------------
  initial begin : mem_driver
    bit busy = 0;
    int waits = 0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.imem_ack = 1'b0;
      if (!reset || !bus.imem_req) begin
        busy = 0;
      end else begin
        if (!busy) begin
          busy  = 1;
          waits = $urandom_range(0, mem_wait_max);
        end
        if (waits == 0) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = rdata_of(bus.imem_addr);
          busy           = 0;
        end else begin
          waits--;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Tracks what the queue must hold and what must be requested next, from the
  // queue rules alone: words arrive in address order, flush empties everything,
  // and a request caught by a flush is completed and thrown away.
  logic              exp_req    = 1'b0;
  logic [ADDR_W-1:0] model_pc   = RESET_PC;
  logic              stale      = 1'b0;
  logic [ADDR_W-1:0] stale_addr = '0;
  int                model_count = 0;

  always @(negedge clk) begin : model
    logic ack;
    bit pushed, popped, new_stale;
    check("imem_req", 64'(bus.imem_req), 64'(exp_req));
    if (exp_req) check("imem_addr", 64'(bus.imem_addr), 64'(stale ? stale_addr : model_pc));
    check("count", 64'(bus.count), 64'(model_count));
    check("inst_valid", 64'(bus.inst_valid), 64'(model_count != 0));
    if (model_count == 0) check("empty_head", 64'({bus.inst, bus.inst_pc}), 64'(0));

    if (!reset) begin
      exp_req     = 1'b0;
      model_pc    = RESET_PC;
      stale       = 1'b0;
      model_count = 0;
      exp_q.delete();
    end else begin
      ack = bus.imem_ack && exp_req;
      if (bus.flush) begin
        new_stale = exp_req && !ack;
        if (new_stale && !stale) stale_addr = model_pc;
        stale       = new_stale;
        model_pc    = bus.flush_pc;
        model_count = 0;
        exp_q.delete();
        exp_req     = 1'b1;
      end else begin
        pushed = 0;
        if (ack) begin
          if (stale) begin
            stale = 1'b0;
          end else begin
            exp_q.push_back({rdata_of(model_pc), model_pc});
            model_pc = model_pc + 1'b1;
            pushed   = 1;
          end
        end
        popped      = (model_count != 0) && bus.deq_ready;
        model_count = model_count + int'(pushed) - int'(popped);
        exp_req     = (exp_req && !ack) || (model_count < DEPTH);
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    logic [W-1:0] exp_e;
    if (reset && !bus.flush && bus.inst_valid && bus.deq_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected actual=%0h required=none t=%0t",
                 {bus.inst, bus.inst_pc}, $time);
      end else begin
        exp_e = exp_q.pop_front();
        check("pop_entry", 64'({bus.inst, bus.inst_pc}), 64'(exp_e));
      end
    end
  end

  // ---------------- stimulus driver ----------------
  int ready_pct [NPH] = '{100,   0, 100,  60,  20,  90,  50};
  int flush_pct [NPH] = '{  0,   0,   0,   6,   4,  12,   5};
  int wait_max  [NPH] = '{  0,   0,   3,   3,   2,   0,   3};
  int rst_pct   [NPH] = '{  0,   0,   0,   0,   0,   0,   2};
  int ncycles   [NPH] = '{200,  30, 200, 600, 600, 600, 600};

  task automatic drive_cycle(input int ph);
    @(posedge clk);
    #1;
    reset         = !($urandom_range(0, 99) < rst_pct[ph]);
    bus.deq_ready = ($urandom_range(0, 99) < ready_pct[ph]);
    bus.flush     = ($urandom_range(0, 99) < flush_pct[ph]);
    if (bus.flush) begin
      if ($urandom_range(0, 3) == 0) bus.flush_pc = 19'h7FFFF - ADDR_W'($urandom_range(0, 2));
      else                           bus.flush_pc = ADDR_W'($urandom_range(0, 19'h7FFFF));
    end
  endtask

  initial begin : stimulus
    bus.flush     = 1'b0;
    bus.flush_pc  = '0;
    bus.deq_ready = 1'b0;
    reset         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int ph = 0; ph < NPH; ph++) begin
      mem_wait_max = wait_max[ph];
      for (int c = 0; c < ncycles[ph]; c++) drive_cycle(ph);
    end
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.deq_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
